process_scheduler_rr: RTL and testbench
=======================================

Name: process_scheduler_rr

Overview:
- Round-robin scheduler for the multiprogrammed MIPS core.
- Selects the next runnable process index and drives the index/Change_Offset pair that programs the per-process memory offset (partition base = index × PARTITION_SIZE).
- Sequences context save/restore handshakes, enforces a fixed time quantum, and retires processes that execute halt.
- Stalls the CPU whenever a process is not in its run slot.

Parameters:
- NUM_PROC, 14, number of process slots (1..16; index is 4 bits).
- QUANTUM, 100, run cycles per time slice (≥2).
- PARTITION_SIZE, 150, words per process memory partition.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Enable  input  1  scheduler enable.
- Process_Valid  input  NUM_PROC  mask of loaded processes; sampled only in SELECT.
- Halt  input  1  current process executed halt; valid only in RUN.
- Save_Done  input  1  context-save complete acknowledge.
- Restore_Done  input  1  context-restore complete acknowledge.
- Indice_Processo  output  4  current process index (registered).
- Change_Offset  output  1  one-cycle strobe: offset logic must load the new partition.
- Offset  output  32  registered partition base = Indice_Processo × PARTITION_SIZE.
- Save_Context  output  1  request context save; level, held until Save_Done.
- Restore_Context  output  1  request context restore; level, held until Restore_Done.
- Cpu_Stall  output  1  1 in every state except RUN.
- Process_Done  output  NUM_PROC  sticky mask of halted processes.
- All_Done  output  1  high in FINISHED.
- Quantum_Count  output  16  cycles elapsed in the current slice.

Behaviour:
- Reset (async, Reset=0):
  - State = IDLE.
  - Indice_Processo = 0, Offset = 0, Process_Done = 0, Quantum_Count = 0.
  - Change_Offset, Save_Context, Restore_Context and All_Done = 0; Cpu_Stall = 1.
- States: IDLE, SELECT, LOAD, RESTORE, RUN, SAVE, FINISHED.
- IDLE:
  - Process_Done cleared on entry.
  - Enable=1 → SELECT. The search pointer starts so that the first pick is the lowest eligible index.
- SELECT (1 cycle):
  - Eligible = Process_Valid & ~Process_Done.
  - Pick the first eligible index strictly after the current index, wrapping modulo NUM_PROC; the current index itself is checked last.
  - None eligible → FINISHED. Otherwise register Indice_Processo and go to LOAD.
- LOAD (1 cycle):
  - Change_Offset = 1.
  - Offset updates on this cycle's edge to index × PARTITION_SIZE, computed at 32 bits with no truncation (13 × 150 = 1950).
  - Next state: RESTORE.
- RESTORE:
  - Restore_Context = 1 until Restore_Done is sampled high, then go to RUN.
  - Quantum_Count = 0 on entry to RUN.
- RUN:
  - Cpu_Stall = 0; Quantum_Count increments each cycle.
  - Halt=1: set Process_Done[index] and go to SELECT; no save.
  - Otherwise, if Quantum_Count == QUANTUM−1: go to SAVE.
  - Halt and quantum expiry in the same cycle: Halt wins.
- SAVE:
  - Save_Context = 1 until Save_Done, then go to SELECT.
- FINISHED:
  - All_Done = 1.
  - Enable=0 → IDLE.
- Enable=0:
  - In RUN, SELECT or LOAD: go to IDLE on the next edge.
  - In SAVE or RESTORE: finish the handshake, then go to IDLE.
  - Elsewhere: ignored.
- Single eligible process: on quantum expiry it re-selects itself. The full SAVE/LOAD/RESTORE sequence still executes and Change_Offset still pulses.
- Process_Valid changes mid-slice take effect at the next SELECT.
- Save_Done or Restore_Done outside its own state: ignored.
- Latency:
  - Halt → next process in RUN = 3 cycles + restore handshake.
  - Quantum expiry → next RUN = save handshake + 3 cycles + restore handshake.
- Reset mid-operation: immediate return to reset values. Any pending handshake is abandoned and Save_Context/Restore_Context drop asynchronously.

Test Plan:
- Reset, then release with Enable=0 → Cpu_Stall=1, Offset=0, all strobes 0, state stays IDLE.
- Process_Valid=0b0000_0000_1011, QUANTUM=4, acks returned 1 cycle after each request → run order 0,1,3,0,…; Offsets 0, 150, 450, 0; exactly 4 RUN cycles per slice; one Change_Offset pulse per switch.
- Halt in RUN of index 1 → Process_Done[1]=1, no Save_Context, next run is index 3; index 1 never runs again.
- Halt asserted on the cycle Quantum_Count==QUANTUM−1 → treated as halt: Done bit set, no save.
- Valid=0b1 only; halt after two slices → self-reselect twice (Offset stays 0, Change_Offset still pulses), then FINISHED with All_Done=1; Enable=0 → IDLE with Process_Done cleared.
- Reset=0 asserted while Restore_Context is high, Restore_Done withheld → all outputs reach reset values without a clock edge; after release with Enable=1, index 13 only valid → Offset=1950.

Source files
------------

// File: rtl/process_scheduler_rr_if.sv
// Scheduler-to-core bundle: run control, context handshakes,
// offset programming and status.
interface process_scheduler_rr_if #(
   parameter int NUM_PROC = 14
);
   logic                Enable;
   logic [NUM_PROC-1:0] Process_Valid;
   logic                Halt;
   logic                Save_Done;
   logic                Restore_Done;
   logic [3:0]          Indice_Processo;
   logic                Change_Offset;
   logic [31:0]         Offset;
   logic                Save_Context;
   logic                Restore_Context;
   logic                Cpu_Stall;
   logic [NUM_PROC-1:0] Process_Done;
   logic                All_Done;
   logic [15:0]         Quantum_Count;

   modport master (
      input  Enable, Process_Valid, Halt,
      input  Save_Done, Restore_Done,
      output Indice_Processo, Change_Offset, Offset,
      output Save_Context, Restore_Context, Cpu_Stall,
      output Process_Done, All_Done, Quantum_Count
   );

   modport slave (
      output Enable, Process_Valid, Halt,
      output Save_Done, Restore_Done,
      input  Indice_Processo, Change_Offset, Offset,
      input  Save_Context, Restore_Context, Cpu_Stall,
      input  Process_Done, All_Done, Quantum_Count
   );
endinterface

// File: rtl/process_scheduler_rr.sv
// Round-robin process scheduler: picks the next runnable slot,
// programs its memory partition and sequences save/restore.
module process_scheduler_rr #(
   parameter int NUM_PROC       = 14,
   parameter int QUANTUM        = 100,
   parameter int PARTITION_SIZE = 150
) (
   input logic                   Clock,
   input logic                   Reset,
   process_scheduler_rr_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, SELECT, LOAD, RESTORE, RUN, SAVE, FINISHED
   } state_t;

   state_t              state, next;
   logic [3:0]          idx, last, pick;
   logic                found;
   logic [4:0]          j;
   logic [31:0]         offset;
   logic [NUM_PROC-1:0] done, elig;
   logic [15:0]         qcount;

   assign elig = bus.Process_Valid & ~done;

   // Scan starts just after last; last itself is reached on the final step.
   always_comb begin
      found = 1'b0;
      pick  = idx;
      j     = '0;
      for (int k = 1; k <= NUM_PROC; k++) begin
         j = 5'(last) + 5'(k);
         if (j >= 5'(NUM_PROC)) j = j - 5'(NUM_PROC);
         if (!found && elig[j[3:0]]) begin
            found = 1'b1;
            pick  = j[3:0];
         end
      end
   end

   always_comb begin
      next = state;
      unique case (state)
         IDLE:
            if (bus.Enable) next = SELECT;
         SELECT:
            if (!bus.Enable) next = IDLE;
            else if (found) next = LOAD;
            else            next = FINISHED;
         LOAD:
            next = bus.Enable ? RESTORE : IDLE;
         RESTORE:
            if (bus.Restore_Done) next = bus.Enable ? RUN : IDLE;
         RUN:
            if (!bus.Enable) next = IDLE;
            else if (bus.Halt) next = SELECT;
            else if (qcount == 16'(QUANTUM - 1)) next = SAVE;
         SAVE:
            if (bus.Save_Done) next = bus.Enable ? SELECT : IDLE;
         FINISHED:
            if (!bus.Enable) next = IDLE;
         default:
            next = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state  <= IDLE;
         idx    <= '0;
         last   <= 4'(NUM_PROC - 1);
         offset <= '0;
         done   <= '0;
         qcount <= '0;
      end else begin
         state <= next;
         unique case (state)
            IDLE:
               last <= 4'(NUM_PROC - 1);
            SELECT:
               if (found && bus.Enable) begin
                  idx  <= pick;
                  last <= pick;
               end
            LOAD:
               offset <= 32'(idx) * 32'(PARTITION_SIZE);
            RESTORE:
               qcount <= '0;
            RUN: begin
               qcount <= qcount + 16'd1;
               if (bus.Halt && bus.Enable) done[idx] <= 1'b1;
            end
            default: ;
         endcase
         // Every entry into IDLE starts a fresh batch.
         if (next == IDLE) done <= '0;
      end
   end

   assign bus.Indice_Processo = idx;
   assign bus.Offset          = offset;
   assign bus.Process_Done    = done;
   assign bus.Quantum_Count   = qcount;
   assign bus.Change_Offset   = (state == LOAD);
   assign bus.Restore_Context = (state == RESTORE);
   assign bus.Save_Context    = (state == SAVE);
   assign bus.Cpu_Stall       = (state != RUN);
   assign bus.All_Done        = (state == FINISHED);
endmodule

// File: tb/tb_process_scheduler_rr.sv
// Directed bench for process_scheduler_rr with a 4-cycle quantum;
// inputs change and outputs are sampled on the falling edge.
module tb_process_scheduler_rr;
   localparam int NP = 14;
   localparam int Q  = 4;
   localparam int PS = 150;

   logic Clock = 1'b0;
   logic Reset;
   int   total = 0;
   int   bad   = 0;

   process_scheduler_rr_if #(.NUM_PROC(NP)) bus ();

   process_scheduler_rr #(
      .NUM_PROC(NP),
      .QUANTUM(Q),
      .PARTITION_SIZE(PS)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus(bus)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(negedge Clock);
   endtask

   task automatic chk1(input string tag, input logic obs,
                       input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Entered with the DUT in SELECT; returns with it in SELECT again.
   task automatic slice(input int ei, input int eoff, input int halt_at);
      int w;
      bit halted;
      w = 0;
      halted = 0;
      while (bus.Change_Offset !== 1'b1 && w < 10) begin
         tick();
         w++;
      end
      chk32("sel_latency", w, 1);
      chk32("index", 32'(bus.Indice_Processo), ei);
      chk1("stall_load", bus.Cpu_Stall, 1'b1);
      tick();
      chk32("offset", bus.Offset, eoff);
      chk1("pulse_once", bus.Change_Offset, 1'b0);
      chk1("restore_req", bus.Restore_Context, 1'b1);
      tick();
      chk1("restore_hold", bus.Restore_Context, 1'b1);
      bus.Restore_Done = 1'b1;
      tick();
      bus.Restore_Done = 1'b0;
      for (int c = 0; c < Q; c++) begin
         chk1("run_stall", bus.Cpu_Stall, 1'b0);
         chk32("qcount", 32'(bus.Quantum_Count), c);
         if (c == halt_at) begin
            bus.Halt = 1'b1;
            tick();
            bus.Halt = 1'b0;
            halted = 1;
            break;
         end
         tick();
      end
      chk1("stall_after", bus.Cpu_Stall, 1'b1);
      if (halted) begin
         chk1("no_save", bus.Save_Context, 1'b0);
      end else begin
         chk1("save_req", bus.Save_Context, 1'b1);
         tick();
         chk1("save_hold", bus.Save_Context, 1'b1);
         bus.Save_Done = 1'b1;
         tick();
         bus.Save_Done = 1'b0;
      end
   endtask

   initial begin
      Reset = 1'b0;
      bus.Enable = 1'b0;
      bus.Process_Valid = '0;
      bus.Halt = 1'b0;
      bus.Save_Done = 1'b0;
      bus.Restore_Done = 1'b0;
      #1;
      chk1("rst_stall", bus.Cpu_Stall, 1'b1);
      chk32("rst_offset", bus.Offset, 0);
      chk32("rst_index", 32'(bus.Indice_Processo), 0);
      tick();
      tick();
      Reset = 1'b1;
      repeat (3) tick();
      chk1("idle_stall", bus.Cpu_Stall, 1'b1);
      chk1("idle_chg", bus.Change_Offset, 1'b0);
      chk1("idle_rest", bus.Restore_Context, 1'b0);
      chk1("idle_save", bus.Save_Context, 1'b0);
      chk1("idle_all", bus.All_Done, 1'b0);
      chk32("idle_offset", bus.Offset, 0);
      chk32("idle_qc", 32'(bus.Quantum_Count), 0);

      bus.Process_Valid = 14'b00_0000_0000_1011;
      bus.Enable = 1'b1;
      tick();
      slice(0, 0, -1);
      slice(1, 150, 2);
      chk32("done_h1", 32'(bus.Process_Done), 32'h2);
      slice(3, 450, -1);
      slice(0, 0, Q - 1);
      chk32("done_hq", 32'(bus.Process_Done), 32'h3);
      slice(3, 450, -1);
      slice(3, 450, 1);
      tick();
      chk1("fin_all", bus.All_Done, 1'b1);
      chk1("fin_stall", bus.Cpu_Stall, 1'b1);
      chk32("fin_done", 32'(bus.Process_Done), 32'hb);
      bus.Enable = 1'b0;
      tick();
      chk1("idle_all2", bus.All_Done, 1'b0);
      chk32("done_clr", 32'(bus.Process_Done), 0);

      bus.Process_Valid = 14'h1;
      bus.Enable = 1'b1;
      tick();
      slice(0, 0, -1);
      slice(0, 0, -1);
      slice(0, 0, 1);
      tick();
      chk1("fin_all2", bus.All_Done, 1'b1);
      chk32("fin_done2", 32'(bus.Process_Done), 32'h1);
      bus.Enable = 1'b0;
      tick();
      chk32("done_clr2", 32'(bus.Process_Done), 0);

      bus.Process_Valid = 14'h2000;
      bus.Enable = 1'b1;
      repeat (3) tick();
      chk1("pend_rest", bus.Restore_Context, 1'b1);
      chk32("pend_idx", 32'(bus.Indice_Processo), 13);
      #2 Reset = 1'b0;
      #1;
      chk1("arst_rest", bus.Restore_Context, 1'b0);
      chk1("arst_save", bus.Save_Context, 1'b0);
      chk1("arst_stall", bus.Cpu_Stall, 1'b1);
      chk1("arst_chg", bus.Change_Offset, 1'b0);
      chk32("arst_idx", 32'(bus.Indice_Processo), 0);
      chk32("arst_off", bus.Offset, 0);
      chk32("arst_qc", 32'(bus.Quantum_Count), 0);
      @(negedge Clock);
      Reset = 1'b1;
      tick();
      slice(13, 1950, 0);
      tick();
      chk1("fin_all3", bus.All_Done, 1'b1);
      chk32("fin_done3", 32'(bus.Process_Done), 32'h2000);
      bus.Enable = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
